// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
//   fetch_entry_t : one buffered fetch (pc + instruction word)
//   fetch_state_t : fetch controller FSM states
//   IMEM_WORDS    : instruction ROM depth in 32-bit words
//   PC_STEP       : byte increment between sequential instructions
package fetch_pkg;

  localparam int unsigned IMEM_WORDS = 64;
  localparam int unsigned PC_STEP    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry circular FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears all entries)
//   push, din   : write din at the tail (caller guarantees room or a same-cycle pop)
//   pop         : drop the head entry (ignored when empty)
//   flush       : discard all entries; overrides push and pop
//   count       : number of valid entries
//   head        : oldest entry (zero after reset)
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer increment that wraps at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequential instruction fetch from a combinational ROM into
// a small buffer feeding decode through a valid/ready handshake, with
// redirect (flush + new pc) and halt support.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cnt output.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : word-aligned byte address to the ROM (the pc register)
//   imem_instr      : ROM word for imem_addr, same cycle
//   redirect_valid  : flush buffer and load redirect_pc (low 2 bits dropped)
//   redirect_pc     : redirect target
//   halt_req        : level request to stop fetching
//   out_valid/out_ready/out_instr/out_pc : decode handshake, driven from buffer head
//   halted          : FSM in HALTED and buffer empty
//   stall_cnt       : (FETCH_PERF_CNT_EN) saturating count of valid & !ready cycles
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc;
  fetch_state_t     state;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     enq_entry;
  logic             xfer;
  logic             enq;
  logic             unused_rpc_lsb;

  assign unused_rpc_lsb = &{1'b0, redirect_pc[1:0]};

  assign xfer = out_valid & out_ready;

  // A slot freed by this cycle's transfer can be refilled in the same cycle.
  assign enq = (state == RUN) & ~halt_req & ~redirect_valid &
               ((count < CNT_W'(BUF_DEPTH)) | xfer);

  assign enq_entry = '{pc: pc, instr: imem_instr};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (xfer),
    .flush (redirect_valid),
    .din   (enq_entry),
    .count (count),
    .head  (head)
  );

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = (state == HALTED) & (count == '0);

  // PC register and RUN/HALTED state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= {RESET_PC[31:2], 2'b00};
      state <= RUN;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (enq) begin
        pc <= pc + 32'(PC_STEP);
      end
      case (state)
        RUN:     if (halt_req)  state <= HALTED;
        HALTED:  if (!halt_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating decode back-pressure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the fetch controller.
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, halt_req, out_valid, out_ready, halted;
  logic [31:0] w_addr, w_instr, w_out_instr, w_out_pc;
  logic        w_valid, w_halted;
  logic        w_ready, w_redir, w_halt;
  logic [31:0] w_rpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, w_stall_cnt;
`endif

  logic [31:0] rom [IMEM_WORDS];
  assign imem_instr = rom[imem_addr[7:2]];
  assign w_instr    = rom[w_addr[7:2]];

  assign w_ready = 1'b1;
  assign w_redir = 1'b0;
  assign w_halt  = 1'b0;
  assign w_rpc   = 32'h0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  imem_fetch_ctrl #(.RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (w_addr),
    .imem_instr     (w_instr),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc),
    .halt_req       (w_halt),
    .out_valid      (w_valid),
    .out_ready      (w_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .halted         (w_halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (w_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  logic         m_halt;
  logic [31:0]  m_stall;
  logic [31:0]  accepted[$];

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("halted", 32'(halted), 32'(m_halt && (mq.size() == 0)));
    check("addr", imem_addr, m_pc);
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
    end
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // Apply one cycle of inputs (called at negedge); model advances with the edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
    int sz;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    #1;
    if (out_valid && rdy) accepted.push_back(out_pc);
    sz = mq.size();
    if (sz > 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (sz > 0 && rdy) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (!m_halt && !hr && mq.size() < DEPTH) begin
      mq.push_back('{pc: m_pc, instr: rom[m_pc[7:2]]});
      m_pc = m_pc + 32'd4;
    end
    if (!m_halt && hr) m_halt = 1'b1;
    else if (m_halt && !hr) m_halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset between edges, check it acts immediately, release at a negedge.
  task automatic do_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wrap_addr", w_addr, WRAP_PC);
    check("rst_wrap_valid", 32'(w_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall", stall_cnt, 32'h0);
    check("rst_wrap_stall", w_stall_cnt, 32'h0);
`endif
    mq.delete();
    m_pc    = 32'h0;
    m_halt  = 1'b0;
    m_stall = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    int n8, n12;
    logic hr;
    clk            = 1'b0;
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    n_vec          = 0;
    n_err          = 0;
    for (int i = 0; i < int'(IMEM_WORDS); i++) rom[i] = 32'(i);
    @(negedge clk);

    // Streaming with decode always ready
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      check("seq_pc", out_pc, 32'(4 * i));
      check("seq_instr", out_instr, 32'(i));
    end

    // Decode stalled for 5 cycles
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_hold_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt4", stall_cnt, 32'd4);
`endif

    // Redirect while full
    cycle(1'b0, 1'b1, 32'h0000_0042, 1'b0);
    check("redir_flush", 32'(out_valid), 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("redir_out_pc", out_pc, 32'h40);

    // Redirect coinciding with transfer of pc 8
    do_reset();
    accepted.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("xfer_head", out_pc, 32'h8);
    cycle(1'b1, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    n8 = 0;
    n12 = 0;
    foreach (accepted[k]) begin
      if (accepted[k] == 32'h8) n8++;
      if (accepted[k] == 32'hC) n12++;
    end
    check("pc8_once", 32'(n8), 32'd1);
    check("no_pc12", 32'(n12), 32'd0);

    // Halt with two entries buffered
    do_reset();
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("halt_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_done", 32'(halted), 32'h1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_frozen", imem_addr, 32'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("resume_valid", 32'(out_valid), 32'h1);
    check("resume_pc", out_pc, 32'h8);

    // PC wrap on the second instance
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_pc0", w_out_pc, WRAP_PC);
    check("wrap_instr0", w_out_instr, rom[63]);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_pc1", w_out_pc, 32'h0);
    check("wrap_instr1", w_out_instr, rom[0]);
    check("wrap_halted", 32'(w_halted), 32'h0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("post_rst_pc", out_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < int'(IMEM_WORDS); i++) rom[i] = $urandom;
    do_reset();
    hr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) hr = ~hr;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        hr = 1'b0;
      end else begin
        cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), $urandom, hr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
